i2c_slave: RTL and testbench
============================

# i2c_slave

Synchronous I2C target that sits on the far side of the bus from `i2c_master` and consumes its `sda`/`scl` traffic. It oversamples the bus on the system clock, detects START and STOP, matches a fixed 7-bit address and services writes and reads against an internal 16-byte register file with an auto-incrementing pointer. A host-side read port and a write-event strobe expose the register contents to the rest of the design. There is no clock stretching; `scl` is input only.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this target acknowledges.
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `scl`  in  1: bus clock, pulled up externally.
- `sda`  inout  1: bus data, open-drain. Driven 0 or released (z), never driven 1.
- `host_rd_addr`  in  4: register-file index for the host read port.
- `host_rd_data`  out  8: `reg[host_rd_addr]`, registered with 1-cycle latency.
- `wr_valid`  out  1: 1-cycle pulse when a bus data byte is committed to a register.
- `wr_addr`  out  4: register index of that write, valid with `wr_valid`.
- `wr_data`  out  8: byte written, valid with `wr_valid`.
- `busy`  out  1: high from an address match until STOP, or until the START that ends the transaction.

## Operation
- Input conditioning: `scl` and `sda` each pass through 2-flop synchronizers; a third stage feeds the edge detectors.
  - `scl_rise` / `scl_fall`: 1-cycle pulses.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- START in any state goes to ADDR: clears the 3-bit bit counter, releases `sda`, and abandons any partial byte. This covers repeated START.
- STOP in any state goes to IDLE: releases `sda`, drops `busy`.
- ADDR: shift `sda` MSB-first on each `scl_rise`. After the 8th bit:
  - `{SLAVE_ADDR,R/W}` matches → ADDR_ACK, `busy` goes to 1.
  - Mismatch → WAIT_STOP, no ACK.
- ADDR_ACK: drive `sda` low on the next `scl_fall`; release it on the following `scl_fall`.
  - W → WR_BYTE, with the first-byte flag set.
  - R → RD_BYTE; MSB of `reg[ptr]` is driven on that same release edge.
- WR_BYTE: 8 bits sampled on `scl_rise`. On the 8th sample:
  - First byte after address: `ptr <= byte[3:0]`; the upper nibble is ignored.
  - Any later byte: `reg[ptr] <= byte`, pulse `wr_valid` with `wr_addr=ptr`, `wr_data=byte`, then `ptr <= ptr+1`. The pointer wraps 15→0.
  - Then go to WR_ACK. Every write byte is ACKed.
- WR_ACK: same ACK drive/release rule as ADDR_ACK, then return to WR_BYTE.
- RD_BYTE: drive the shift register MSB-first, updating on each `scl_fall` (bit 1 = release, bit 0 = pull low). After the 8th bit's `scl_fall`, release `sda` and go to RD_ACK.
- RD_ACK: sample `sda` on `scl_rise`; `ptr` increments (wraps) in both cases.
  - 0 (ACK) → load `reg[ptr]` and go to RD_BYTE.
  - 1 (NACK) → WAIT_STOP.
- WAIT_STOP: `sda` released; leave only on START or STOP.
- Host port: `host_rd_data <= reg[host_rd_addr]` every cycle. If the host reads the same index on the cycle a bus write lands, it gets the old value; the new value appears on the next cycle.

## Timing
- Reset values: `sda` released, `busy`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `host_rd_data`=0, `ptr`=0, all registers 0, state IDLE.
- Reset mid-transfer: `sda` is released on the cycle after `rst` is sampled. The block ignores the bus until the next START.
- Pin-to-detect latency: 3 clk from a pin edge to the `scl_rise`/`scl_fall`/START/STOP pulse.
- `sda` drive changes 1 clk after `scl_fall` is detected, i.e. 4 clk after the pin edge.
- Each SCL high and low phase must be at least 6 clk. Slower traffic is out of spec.
- `wr_valid` is asserted 1 clk after the 8th `scl_rise` of a data byte.
- START/STOP detection has priority over the bit sample in the same cycle.

## Test plan
- Write: START, 0xA0, 0x03, 0x11, 0x22, STOP → all ACKs 0; `wr_valid` twice (3/0x11, 4/0x22); `host_rd_addr`=4 returns 0x22.
- Repeated-START read: START, 0xA0, 0x03, Sr, 0xA1, read 2 bytes (ACK then NACK), STOP → bus bytes 0x11, 0x22; `busy` falls at STOP.
- Address mismatch: START, 0xA2, 0x55, STOP → `sda` never driven low; no `wr_valid`; `busy` stays 0.
- Pointer wrap: write pointer 0x0F, then data 0xAA, 0xBB → reg[15]=0xAA, reg[0]=0xBB.
- Collision: host reads index 3 on the same cycle as bus write 0x77 to index 3 → old value that cycle, 0x77 the next.
- Reset mid-read: assert `rst` while `sda` is held low in RD_BYTE → `sda` released next cycle; remaining SCL pulses ignored; a new START plus 0xA1 is ACKed and returns reg[0]=0x00.

Source files
------------

// File: rtl/i2c_slave_if.sv
// Host-side view of the I2C target: register read port, write-event strobe and status.
// wr_valid is a one-cycle strobe with no ready: the receiver must take wr_addr/wr_data in the cycle it is high.
interface i2c_slave_if;
  logic [3:0] host_rd_addr;
  logic [7:0] host_rd_data;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [2:0] state_dbg;

  modport slave (
    input  host_rd_addr,
    output host_rd_data, wr_valid, wr_addr, wr_data, busy, state_dbg
  );

  modport master (
    output host_rd_addr,
    input  host_rd_data, wr_valid, wr_addr, wr_data, busy, state_dbg
  );
endinterface

// File: rtl/i2c_slave.sv
// Oversampling I2C target with a 16-byte register file and auto-incrementing pointer.
// The bus is sampled on clk; sda is open-drain (driven low or released, never high).
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scl,
  inout  wire          sda,
  i2c_slave_if.slave   host
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  state_t      state, state_next;
  logic        scl_s1, scl_s2, scl_s3, sda_s1, sda_s2, sda_s3;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [3:0]  ptr;
  logic        first_byte, rw, ack_on, msb_pending, sda_low;
  logic [7:0]  regs [16];
  logic        sda_in, addr_match;
  logic [7:0]  shifted;

  assign sda        = sda_low ? 1'b0 : 1'bz;
  assign sda_in     = sda_s3;
  assign shifted    = {shift[6:0], sda_in};
  assign addr_match = (shift[6:0] == SLAVE_ADDR);
  assign host.state_dbg = state;

  // Sync flops reset to the idle-high bus level so reset never fakes a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_s3} <= 3'b111;
      {sda_s1, sda_s2, sda_s3} <= 3'b111;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_s1    <= scl;
      scl_s2    <= scl_s1;
      scl_s3    <= scl_s2;
      sda_s1    <= sda;
      sda_s2    <= sda_s1;
      sda_s3    <= sda_s2;
      scl_rise  <= scl_s2 & ~scl_s3;
      scl_fall  <= ~scl_s2 & scl_s3;
      start_det <= scl_s2 & scl_s3 & ~sda_s2 & sda_s3;
      stop_det  <= scl_s2 & scl_s3 & sda_s2 & ~sda_s3;
    end
  end

  always_comb begin
    state_next = state;
    if (start_det)     state_next = ADDR;
    else if (stop_det) state_next = IDLE;
    else begin
      case (state)
        ADDR:     if (scl_rise && bit_cnt == 3'd7) state_next = addr_match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall && ack_on)          state_next = rw ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (scl_rise && bit_cnt == 3'd7) state_next = WR_ACK;
        WR_ACK:   if (scl_fall && ack_on)          state_next = WR_BYTE;
        RD_BYTE:  if (scl_fall && !msb_pending && bit_cnt == 3'd7) state_next = RD_ACK;
        RD_ACK:   if (scl_rise)                    state_next = sda_in ? WAIT_STOP : RD_BYTE;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      bit_cnt           <= 3'd0;
      shift             <= 8'd0;
      ptr               <= 4'd0;
      first_byte        <= 1'b0;
      rw                <= 1'b0;
      ack_on            <= 1'b0;
      msb_pending       <= 1'b0;
      sda_low           <= 1'b0;
      host.busy         <= 1'b0;
      host.wr_valid     <= 1'b0;
      host.wr_addr      <= 4'd0;
      host.wr_data      <= 8'd0;
      host.host_rd_data <= 8'd0;
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
    end else begin
      state             <= state_next;
      host.wr_valid     <= 1'b0;
      host.host_rd_data <= regs[host.host_rd_addr];
      if (start_det) begin
        bit_cnt     <= 3'd0;
        sda_low     <= 1'b0;
        host.busy   <= 1'b0;
        ack_on      <= 1'b0;
        msb_pending <= 1'b0;
      end else if (stop_det) begin
        sda_low   <= 1'b0;
        host.busy <= 1'b0;
        ack_on    <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift   <= shifted;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw     <= sda_in;
              ack_on <= 1'b0;
              if (addr_match) host.busy <= 1'b1;
            end
          end
          // First fall pulls the ACK low, the second releases it (or presents read MSB).
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_low <= 1'b1;
              ack_on  <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              bit_cnt <= 3'd0;
              if (state == ADDR_ACK && rw) begin
                sda_low     <= ~regs[ptr][7];
                shift       <= {regs[ptr][6:0], 1'b0};
                msb_pending <= 1'b0;
              end else begin
                sda_low <= 1'b0;
                if (state == ADDR_ACK) first_byte <= 1'b1;
              end
            end
          end
          WR_BYTE: if (scl_rise) begin
            shift   <= shifted;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (first_byte) begin
                ptr        <= shifted[3:0];
                first_byte <= 1'b0;
              end else begin
                regs[ptr]     <= shifted;
                host.wr_valid <= 1'b1;
                host.wr_addr  <= ptr;
                host.wr_data  <= shifted;
                ptr           <= ptr + 4'd1;
              end
            end
          end
          // After a master ACK the MSB waits for the next fall (msb_pending).
          RD_BYTE: if (scl_fall) begin
            if (msb_pending) begin
              sda_low     <= ~shift[7];
              shift       <= {shift[6:0], 1'b0};
              msb_pending <= 1'b0;
            end else if (bit_cnt == 3'd7) begin
              sda_low <= 1'b0;
            end else begin
              sda_low <= ~shift[7];
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          RD_ACK: if (scl_rise) begin
            ptr     <= ptr + 4'd1;
            bit_cnt <= 3'd0;
            if (!sda_in) begin
              shift       <= regs[ptr + 4'd1];
              msb_pending <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged I2C master tasks, write-event monitor, per-scenario checks.
module tb_i2c_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_if hif();

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk  (clk),
    .rst  (rst),
    .scl  (scl),
    .sda  (sda),
    .host (hif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dut_low_cnt = 0;
  logic busy_seen = 1'b0;
  logic grab_next = 1'b0;
  logic [7:0] hrd_at_wr = 8'd0;
  logic [7:0] hrd_after = 8'd0;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  // Monitor: records write events, host data around them, and any low drive from the target.
  always @(negedge clk) begin
    if (sda === 1'b0 && !m_sda_low) dut_low_cnt++;
    if (hif.busy) busy_seen = 1'b1;
    if (grab_next) begin
      hrd_after = hif.host_rd_data;
      grab_next = 1'b0;
    end
    if (hif.wr_valid) begin
      obs_q.push_back({hif.wr_addr, hif.wr_data});
      hrd_at_wr = hif.host_rd_data;
      grab_next = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    scl = 1'b0;
    wait_clk(2);
    m_sda_low = 1'b0;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(8);
    m_sda_low = 1'b1;
    wait_clk(8);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(2);
    m_sda_low = 1'b1;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(8);
    m_sda_low = 1'b0;
    wait_clk(8);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(2);
    m_sda_low = !b;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(8);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clk(2);
    m_sda_low = 1'b0;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(4);
    ack = sda;
    wait_clk(4);
    scl = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      wait_clk(2);
      m_sda_low = 1'b0;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(4);
      d[i] = sda;
      wait_clk(4);
      scl = 1'b0;
    end
    send_bit(nack);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hif.host_rd_addr = 4'd0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);
    checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", hif.busy); end
    checks++; if (hif.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", hif.wr_valid); end
    checks++; if (hif.wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", hif.wr_addr); end
    checks++; if (hif.wr_data !== 8'd0) begin errors++; $display("FAIL reset_wr_data: got %h want 00", hif.wr_data); end
    checks++; if (hif.host_rd_data !== 8'd0) begin errors++; $display("FAIL reset_host_rd_data: got %h want 00", hif.host_rd_data); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
    checks++; if (hif.state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", hif.state_dbg); end
  endtask

  task automatic test_write();
    logic acks [4];
    logic [11:0] e, o;
    exp_q.push_back({4'd3, 8'h11});
    exp_q.push_back({4'd4, 8'h22});
    bus_start();
    send_byte(8'hA0, acks[0]);
    send_byte(8'h03, acks[1]);
    send_byte(8'h11, acks[2]);
    send_byte(8'h22, acks[3]);
    for (int i = 0; i < 4; i++) begin
      checks++; if (acks[i] !== 1'b0) begin errors++; $display("FAIL write_ack%0d: got %b want 0", i, acks[i]); end
    end
    checks++; if (hif.busy !== 1'b1) begin errors++; $display("FAIL write_busy_mid: got %b want 1", hif.busy); end
    bus_stop();
    checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b want 0", hif.busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL write_event_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL write_event: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    hif.host_rd_addr = 4'd4;
    wait_clk(2);
    checks++; if (hif.host_rd_data !== 8'h22) begin errors++; $display("FAIL write_host_rd4: got %h want 22", hif.host_rd_data); end
    hif.host_rd_addr = 4'd3;
    wait_clk(2);
    checks++; if (hif.host_rd_data !== 8'h11) begin errors++; $display("FAIL write_host_rd3: got %h want 11", hif.host_rd_data); end
  endtask

  task automatic test_rep_start_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h03, a1);
    bus_start();
    send_byte(8'hA1, a2);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rd_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (hif.busy !== 1'b1) begin errors++; $display("FAIL rd_busy_mid: got %b want 1", hif.busy); end
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL rd_byte0: got %h want 11", d0); end
    checks++; if (d1 !== 8'h22) begin errors++; $display("FAIL rd_byte1: got %h want 22", d1); end
    bus_stop();
    checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop: got %b want 0", hif.busy); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rd_no_write: got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    dut_low_cnt = 0;
    busy_seen = 1'b0;
    bus_start();
    send_byte(8'hA2, a0);
    send_byte(8'h55, a1);
    bus_stop();
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL mismatch_acks: got %b want 11", {a0, a1}); end
    checks++; if (dut_low_cnt != 0) begin errors++; $display("FAIL mismatch_sda_driven: got %0d low cycles want 0", dut_low_cnt); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b want 0", busy_seen); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mismatch_no_write: got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_ptr_wrap();
    logic a0, a1, a2, a3;
    logic [11:0] e, o;
    exp_q.push_back({4'd15, 8'hAA});
    exp_q.push_back({4'd0, 8'hBB});
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h0F, a1);
    send_byte(8'hAA, a2);
    send_byte(8'hBB, a3);
    bus_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3}); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_event_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL wrap_event: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    hif.host_rd_addr = 4'd15;
    wait_clk(2);
    checks++; if (hif.host_rd_data !== 8'hAA) begin errors++; $display("FAIL wrap_reg15: got %h want aa", hif.host_rd_data); end
    hif.host_rd_addr = 4'd0;
    wait_clk(2);
    checks++; if (hif.host_rd_data !== 8'hBB) begin errors++; $display("FAIL wrap_reg0: got %h want bb", hif.host_rd_data); end
  endtask

  task automatic test_collision();
    logic a0, a1, a2;
    logic [11:0] e, o;
    hif.host_rd_addr = 4'd3;
    exp_q.push_back({4'd3, 8'h77});
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h03, a1);
    send_byte(8'h77, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL coll_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL coll_event_count: got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL coll_event: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (hrd_at_wr !== 8'h11) begin errors++; $display("FAIL coll_old_value: got %h want 11", hrd_at_wr); end
    checks++; if (hrd_after !== 8'h77) begin errors++; $display("FAIL coll_new_value: got %h want 77", hrd_after); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1;
    logic [7:0] d0;
    bus_start();
    send_byte(8'hA1, a0);
    checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL rmr_ack: got %b want 0", a0); end
    wait_clk(6);
    // Pointer is 4 here and reg[4]=0x22, so the target is holding the MSB (0) low.
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rmr_sda_held: got %b want 0", sda); end
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rmr_sda_released: got %b want 1", sda); end
    checks++; if (hif.state_dbg !== 3'd0) begin errors++; $display("FAIL rmr_state: got %0d want 0", hif.state_dbg); end
    dut_low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      wait_clk(8);
      scl = 1'b1;
      wait_clk(8);
      scl = 1'b0;
    end
    checks++; if (dut_low_cnt != 0) begin errors++; $display("FAIL rmr_ignored: got %0d low cycles want 0", dut_low_cnt); end
    bus_start();
    send_byte(8'hA1, a1);
    read_byte(1'b1, d0);
    bus_stop();
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL rmr_new_ack: got %b want 0", a1); end
    checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL rmr_reg0: got %h want 00", d0); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rmr_no_write: got %0d events want 0", obs_q.size()); end
  endtask

  initial begin
    hif.host_rd_addr = 4'd0;
    test_reset();
    test_write();
    test_rep_start_read();
    test_mismatch();
    test_ptr_wrap();
    test_collision();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
